// File: rtl/stim_pattern_gen.sv
// ---------------------------------------------------------------------------
// stim_pattern_gen
//  Programmable data-pattern source for the d_i bus of the long_comb_path
//  timing-stress stages. One instance per clock domain.
//
//  Patterns (selected by the debounced mode):
//    00 count   : seed 0, increment with wrap
//    01 LFSR    : seed LFSR_SEED (0 forced to 1), Galois right shift
//    10 walk    : seed 1, rotate left
//    11 checker : seed 0101..01, bitwise invert each step
//
//  Ports
//    clk      in   1      clock, all logic on posedge
//    rst      in   1      asynchronous reset, active low
//    en_i     in   1      run enable (synchronous to clk)
//    mode_i   in   2      raw switch mode select (asynchronous)
//    div_i    in   DIV_W  step period minus 1 (0 = step every cycle)
//    d_o      out  WIDTH  registered pattern word
//    valid_o  out  1      strobe, high in every cycle in which d_o changes
//    mode_o   out  2      accepted (debounced) mode
// ---------------------------------------------------------------------------
module stim_pattern_gen #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      DIV_W     = 8,
  parameter int unsigned      DB_CYCLES = 1024,
  parameter logic [WIDTH-1:0] LFSR_TAPS = 32'h8020_0003,
  parameter logic [WIDTH-1:0] LFSR_SEED = 32'h0000_0001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic [DIV_W-1:0] div_i,
  output logic [WIDTH-1:0] d_o,
  output logic             valid_o,
  output logic [1:0]       mode_o
);

  localparam int unsigned DB_W = $clog2(DB_CYCLES + 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  // An all-zero LFSR state would lock up, so a zero seed is replaced by 1.
  localparam logic [WIDTH-1:0] SEED_LFSR = (LFSR_SEED == '0) ? ONE : LFSR_SEED;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  // Checkerboard seed: even bits set (5555_5555 for 32 bits).
  logic [WIDTH-1:0] check_seed;
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_check_seed
    assign check_seed[gi] = ((gi % 2) == 0);
  end

  // ---------------------------------------------------------------------
  // Mode input path: 2-flop synchronizer followed by a stability counter.
  // ---------------------------------------------------------------------
  logic [1:0]      sync1_reg, sync2_reg, sync_prev_reg;
  logic [DB_W-1:0] db_cnt_reg;
  logic [1:0]      mode_reg;
  logic            mode_chg_reg;
  logic [DB_W-1:0] stable_cnt;

  // Number of cycles (including the current one) the synced value has held.
  always_comb begin
    stable_cnt = db_cnt_reg + DB_W'(1);
    if (sync2_reg != sync_prev_reg) begin
      stable_cnt = DB_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_reg     <= 2'b00;
      sync2_reg     <= 2'b00;
      sync_prev_reg <= 2'b00;
      db_cnt_reg    <= '0;
      mode_reg      <= 2'b00;
      mode_chg_reg  <= 1'b0;
    end else begin
      sync1_reg     <= mode_i;
      sync2_reg     <= sync1_reg;
      sync_prev_reg <= sync2_reg;
      mode_chg_reg  <= 1'b0;
      if (sync2_reg == mode_reg) begin
        db_cnt_reg <= '0;
      end else if (stable_cnt >= DB_W'(DB_CYCLES)) begin
        // mode_chg is high in the same cycle the new mode becomes visible,
        // so a LOAD triggered by it always picks up the new seed.
        mode_reg     <= sync2_reg;
        mode_chg_reg <= 1'b1;
        db_cnt_reg   <= '0;
      end else begin
        db_cnt_reg <= stable_cnt;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Pattern FSM and datapath
  // ---------------------------------------------------------------------
  state_t           state_reg, state_next;
  logic [WIDTH-1:0] d_reg, d_next;
  logic             valid_reg, valid_next;
  logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
  logic [WIDTH-1:0] seed, step;

  always_comb begin
    seed = '0;
    step = d_reg + ONE;
    unique case (mode_reg)
      2'b00: begin
        seed = '0;
        step = d_reg + ONE;
      end
      2'b01: begin
        seed = SEED_LFSR;
        if (d_reg == '0) begin
          step = SEED_LFSR;
        end else begin
          step = (d_reg >> 1) ^ (d_reg[0] ? LFSR_TAPS : '0);
        end
      end
      2'b10: begin
        seed = ONE;
        step = {d_reg[WIDTH-2:0], d_reg[WIDTH-1]};
      end
      2'b11: begin
        seed = check_seed;
        step = ~d_reg;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    d_next       = d_reg;
    valid_next   = 1'b0;
    div_cnt_next = div_cnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (en_i) state_next = LOAD;
      end
      LOAD: begin
        d_next       = seed;
        valid_next   = 1'b1;
        div_cnt_next = '0;
        state_next   = RUN;
      end
      RUN: begin
        if (mode_chg_reg) begin
          state_next = LOAD;
        end else if (en_i) begin
          // >= so that lowering div_i below the count steps right away.
          if (div_cnt_reg >= div_i) begin
            d_next       = step;
            valid_next   = 1'b1;
            div_cnt_next = '0;
          end else begin
            div_cnt_next = div_cnt_reg + DIV_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      d_reg       <= '0;
      valid_reg   <= 1'b0;
      div_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      d_reg       <= d_next;
      valid_reg   <= valid_next;
      div_cnt_reg <= div_cnt_next;
    end
  end

  assign d_o     = d_reg;
  assign valid_o = valid_reg;
  assign mode_o  = mode_reg;

endmodule
